// File: rtl/layer_wr_sched_pkg.sv
// Shared types, widths and csel encodings for the layer write-port scheduler.
package layer_wr_sched_pkg;

    localparam int unsigned DATAW  = 20;
    localparam int unsigned ADDRW  = 12;
    localparam int unsigned PADDRW = 10;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_L0K0 = 3'b001;
    localparam logic [2:0] SEL_L0K1 = 3'b010;
    localparam logic [2:0] SEL_L1K0 = 3'b011;
    localparam logic [2:0] SEL_L1K1 = 3'b100;
    localparam logic [2:0] SEL_L2   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_MXPL = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CONV = 1'b0,
        GNT_MXPL = 1'b1
    } grant_t;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] d0;
        logic [DATAW-1:0] d1;
    } convPay_t;

    typedef struct packed {
        logic              last;
        logic [PADDRW-1:0] addr;
        logic [DATAW-1:0]  d0;
        logic [DATAW-1:0]  d1;
    } mxplPay_t;

    // Pooled pixel address placed in the 64x64 memory space.
    function automatic logic [ADDRW-1:0] poolAddr(input logic [PADDRW-1:0] a);
        return ADDRW'(a);
    endfunction

    // Flattened address: two consecutive words per pooled pixel.
    function automatic logic [ADDRW-1:0] flatAddr(input logic [PADDRW-1:0] a, input logic lsb);
        return ADDRW'({a, lsb});
    endfunction

endpackage

// File: rtl/layer_wr_sched_if.sv
// Requester handshakes and result-memory write port of the layer write scheduler.
interface layer_wr_sched_if;
    import layer_wr_sched_pkg::*;

    logic              conv_valid;
    logic              conv_ready;
    logic [ADDRW-1:0]  conv_addr;
    logic [DATAW-1:0]  conv_d0;
    logic [DATAW-1:0]  conv_d1;

    logic              mxpl_valid;
    logic              mxpl_ready;
    logic [PADDRW-1:0] mxpl_addr;
    logic [DATAW-1:0]  mxpl_d0;
    logic [DATAW-1:0]  mxpl_d1;
    logic              mxpl_last;

    logic              cwr;
    logic [2:0]        csel;
    logic [ADDRW-1:0]  caddr_wr;
    logic [DATAW-1:0]  cdata_wr;

    modport master (
        output conv_valid, conv_addr, conv_d0, conv_d1,
        output mxpl_valid, mxpl_addr, mxpl_d0, mxpl_d1, mxpl_last,
        input  conv_ready, mxpl_ready,
        input  cwr, csel, caddr_wr, cdata_wr
    );

    modport slave (
        input  conv_valid, conv_addr, conv_d0, conv_d1,
        input  mxpl_valid, mxpl_addr, mxpl_d0, mxpl_d1, mxpl_last,
        output conv_ready, mxpl_ready,
        output cwr, csel, caddr_wr, cdata_wr
    );

endinterface

// File: rtl/sched_hold_reg.sv
// Single-entry payload holding register with valid/ready capture and drain clear.
module sched_hold_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    output logic         ready,
    input  logic [W-1:0] din,
    input  logic         drain,
    output logic         full,
    output logic [W-1:0] dout
);

    // ready is kept as its own flop so it is always the exact inverse of full.
    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            ready <= 1'b1;
            dout  <= '0;
        end else if (valid && ready) begin
            full  <= 1'b1;
            ready <= 1'b0;
            dout  <= din;
        end else if (drain) begin
            full  <= 1'b0;
            ready <= 1'b1;
        end
    end

endmodule

// File: rtl/layer_wr_sched.sv
// Write-port scheduler: expands conv pairs (2 beats) and max-pool pairs (4 beats)
// onto the single result-memory port with round-robin arbitration and busy/done.
module layer_wr_sched
    import layer_wr_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    layer_wr_sched_if.slave  bus
);

    localparam int unsigned CONV_W = $bits(convPay_t);
    localparam int unsigned MXPL_W = $bits(mxplPay_t);

    convPay_t convIn;
    convPay_t convHeld;
    mxplPay_t mxplIn;
    mxplPay_t mxplHeld;
    logic     convFull;
    logic     mxplFull;
    logic     drainConv;
    logic     drainMxpl;

    state_t     state;
    state_t     stateNext;
    logic [1:0] beat;
    logic [1:0] beatNext;
    grant_t     lastGrant;
    grant_t     lastGrantNext;
    logic       doneArm;
    logic       doneArmNext;

    logic             cwrReg;
    logic             cwrNext;
    logic [2:0]       cselReg;
    logic [2:0]       cselNext;
    logic [ADDRW-1:0] caddrReg;
    logic [ADDRW-1:0] caddrNext;
    logic [DATAW-1:0] cdataReg;
    logic [DATAW-1:0] cdataNext;

    assign convIn = '{addr: bus.conv_addr, d0: bus.conv_d0, d1: bus.conv_d1};
    assign mxplIn = '{last: bus.mxpl_last, addr: bus.mxpl_addr, d0: bus.mxpl_d0, d1: bus.mxpl_d1};

    sched_hold_reg #(.W(CONV_W)) u_convHold (
        .clk   (clk),
        .reset (reset),
        .valid (bus.conv_valid),
        .ready (bus.conv_ready),
        .din   (convIn),
        .drain (drainConv),
        .full  (convFull),
        .dout  (convHeld)
    );

    sched_hold_reg #(.W(MXPL_W)) u_mxplHold (
        .clk   (clk),
        .reset (reset),
        .valid (bus.mxpl_valid),
        .ready (bus.mxpl_ready),
        .din   (mxplIn),
        .drain (drainMxpl),
        .full  (mxplFull),
        .dout  (mxplHeld)
    );

    // State, beat counter, arbitration history and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            beat      <= 2'd0;
            lastGrant <= GNT_MXPL;
            doneArm   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cwrReg    <= 1'b0;
            cselReg   <= SEL_NONE;
            caddrReg  <= '0;
            cdataReg  <= '0;
        end else begin
            state     <= stateNext;
            beat      <= beatNext;
            lastGrant <= lastGrantNext;
            doneArm   <= doneArmNext;
            done      <= doneArm;
            cwrReg    <= cwrNext;
            cselReg   <= cselNext;
            caddrReg  <= caddrNext;
            cdataReg  <= cdataNext;
            if (doneArm) begin
                busy <= 1'b0;
            end else if (start) begin
                busy <= 1'b1;
            end
        end
    end

    // Grants wait for a cycle with no beat on the port, which yields the idle gap.
    always_comb begin
        stateNext     = state;
        beatNext      = beat;
        lastGrantNext = lastGrant;
        doneArmNext   = 1'b0;
        drainConv     = 1'b0;
        drainMxpl     = 1'b0;
        cwrNext       = 1'b0;
        cselNext      = SEL_NONE;
        caddrNext     = caddrReg;
        cdataNext     = cdataReg;

        unique case (state)
            ST_IDLE: begin
                if (!cwrReg) begin
                    if (convFull && (!mxplFull || lastGrant == GNT_MXPL)) begin
                        stateNext     = ST_CONV;
                        beatNext      = 2'd1;
                        lastGrantNext = GNT_CONV;
                        cwrNext       = 1'b1;
                        cselNext      = SEL_L0K0;
                        caddrNext     = convHeld.addr;
                        cdataNext     = convHeld.d0;
                    end else if (mxplFull) begin
                        stateNext     = ST_MXPL;
                        beatNext      = 2'd1;
                        lastGrantNext = GNT_MXPL;
                        cwrNext       = 1'b1;
                        cselNext      = SEL_L1K0;
                        caddrNext     = poolAddr(mxplHeld.addr);
                        cdataNext     = mxplHeld.d0;
                    end
                end
            end
            ST_CONV: begin
                cwrNext   = 1'b1;
                cselNext  = SEL_L0K1;
                caddrNext = convHeld.addr;
                cdataNext = convHeld.d1;
                drainConv = 1'b1;
                stateNext = ST_IDLE;
                beatNext  = 2'd0;
            end
            ST_MXPL: begin
                cwrNext = 1'b1;
                unique case (beat)
                    2'd1: begin
                        cselNext  = SEL_L2;
                        caddrNext = flatAddr(mxplHeld.addr, 1'b0);
                        cdataNext = mxplHeld.d0;
                        beatNext  = 2'd2;
                    end
                    2'd2: begin
                        cselNext  = SEL_L1K1;
                        caddrNext = poolAddr(mxplHeld.addr);
                        cdataNext = mxplHeld.d1;
                        beatNext  = 2'd3;
                    end
                    default: begin
                        cselNext    = SEL_L2;
                        caddrNext   = flatAddr(mxplHeld.addr, 1'b1);
                        cdataNext   = mxplHeld.d1;
                        drainMxpl   = 1'b1;
                        doneArmNext = mxplHeld.last;
                        stateNext   = ST_IDLE;
                        beatNext    = 2'd0;
                    end
                endcase
            end
            default: begin
                stateNext = ST_IDLE;
                beatNext  = 2'd0;
            end
        endcase
    end

    assign bus.cwr      = cwrReg;
    assign bus.csel     = cselReg;
    assign bus.caddr_wr = caddrReg;
    assign bus.cdata_wr = cdataReg;

endmodule

// File: tb/tb_layer_wr_sched.sv
// Scoreboard bench for layer_wr_sched: per-requester expected write streams,
// plus cycle-level checks of idle gaps, busy/done and reset behaviour.
module tb_layer_wr_sched;
    import layer_wr_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    layer_wr_sched_if bus();

    layer_wr_sched dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       csel;
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
        bit               first;
        bit               fin;
        bit               last;
    } expBeat_t;

    typedef struct {
        bit isMxpl;
        int cyc;
    } txnLog_t;

    expBeat_t expConv[$];
    expBeat_t expMxpl[$];
    txnLog_t  startLog[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   convWrites  = 0;
    logic rstSampled  = 1'b0;
    logic startSampled = 1'b0;

    // What the DUT saw at the last edge.
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        rstSampled   <= reset;
        startSampled <= start;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired, expected the event (cycle %0d)", name, cyc);
    endtask

    // Reference model: what each accepted transaction must write, in order.
    function automatic void pushConv(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d0,
                                     input logic [DATAW-1:0] d1);
        expConv.push_back('{SEL_L0K0, a, d0, 1'b1, 1'b0, 1'b0});
        expConv.push_back('{SEL_L0K1, a, d1, 1'b0, 1'b1, 1'b0});
    endfunction

    function automatic void pushMxpl(input logic [PADDRW-1:0] pa, input logic [DATAW-1:0] d0,
                                     input logic [DATAW-1:0] d1, input bit last);
        int p;
        p = int'(pa);
        expMxpl.push_back('{SEL_L1K0, ADDRW'(p),         d0, 1'b1, 1'b0, 1'b0});
        expMxpl.push_back('{SEL_L2,   ADDRW'(2 * p),     d0, 1'b0, 1'b0, 1'b0});
        expMxpl.push_back('{SEL_L1K1, ADDRW'(p),         d1, 1'b0, 1'b0, 1'b0});
        expMxpl.push_back('{SEL_L2,   ADDRW'(2 * p + 1), d1, 1'b0, 1'b1, last});
    endfunction

    task automatic sendConv(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d0,
                            input logic [DATAW-1:0] d1, output int acc);
        logic r;
        int   n;
        n = 0;
        acc = -1;
        bus.conv_valid = 1'b1;
        bus.conv_addr  = a;
        bus.conv_d0    = d0;
        bus.conv_d1    = d1;
        forever begin
            r = bus.conv_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                pushConv(a, d0, d1);
                break;
            end
            n++;
            if (n > 500) begin
                failNow("conv accept");
                break;
            end
        end
    endtask

    task automatic sendMxpl(input logic [PADDRW-1:0] a, input logic [DATAW-1:0] d0,
                            input logic [DATAW-1:0] d1, input logic last, output int acc);
        logic r;
        int   n;
        n = 0;
        acc = -1;
        bus.mxpl_valid = 1'b1;
        bus.mxpl_addr  = a;
        bus.mxpl_d0    = d0;
        bus.mxpl_d1    = d1;
        bus.mxpl_last  = last;
        forever begin
            r = bus.mxpl_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                pushMxpl(a, d0, d1, last);
                break;
            end
            n++;
            if (n > 500) begin
                failNow("mxpl accept");
                break;
            end
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expConv.size() != 0 || expMxpl.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) failNow(name);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: checks every cycle against the expected streams and busy/done model.
    initial begin
        int       cont;
        int       s;
        bit       gap;
        bit       doneNext;
        bit       doneNow;
        bit       busyExp;
        expBeat_t e;
        cont = 0; gap = 1'b0; doneNext = 1'b0; busyExp = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rstSampled) begin
                expConv.delete();
                expMxpl.delete();
                cont = 0; gap = 1'b0; doneNext = 1'b0; busyExp = 1'b0;
                chk("reset cwr", 32'(bus.cwr), 0);
                chk("reset csel", 32'(bus.csel), 32'(SEL_NONE));
                chk("reset busy", 32'(busy), 0);
                chk("reset done", 32'(done), 0);
                chk("reset conv_ready", 32'(bus.conv_ready), 1);
                chk("reset mxpl_ready", 32'(bus.mxpl_ready), 1);
            end else begin
                doneNow  = doneNext;
                doneNext = 1'b0;
                if (doneNow) busyExp = 1'b0;
                else if (startSampled) busyExp = 1'b1;
                chk("done", 32'(done), 32'(doneNow));
                chk("busy", 32'(busy), 32'(busyExp));
                s = 0;
                if (cont != 0) begin
                    chk("beat continuity cwr", 32'(bus.cwr), 1);
                    if (bus.cwr) s = cont;
                    cont = 0;
                end else if (gap) begin
                    chk("idle gap cwr", 32'(bus.cwr), 0);
                end else if (bus.cwr) begin
                    if (bus.csel == SEL_L0K0) s = 1;
                    else if (bus.csel == SEL_L1K0) s = 2;
                    else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL first beat csel: got %b expected 001 or 011 (cycle %0d)", bus.csel, cyc);
                    end
                end
                if (!bus.cwr) chk("idle csel", 32'(bus.csel), 32'(SEL_NONE));
                gap = 1'b0;
                if (s != 0) begin
                    if ((s == 1 && expConv.size() == 0) || (s == 2 && expMxpl.size() == 0)) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected write: got csel %b addr %h, expected no write (cycle %0d)",
                                 bus.csel, bus.caddr_wr, cyc);
                    end else begin
                        if (s == 1) begin
                            e = expConv.pop_front();
                            convWrites++;
                        end else begin
                            e = expMxpl.pop_front();
                        end
                        chk("write csel", 32'(bus.csel), 32'(e.csel));
                        chk("write addr", 32'(bus.caddr_wr), 32'(e.addr));
                        chk("write data", 32'(bus.cdata_wr), 32'(e.data));
                        if (e.first) startLog.push_back('{s == 2, cyc});
                        cont     = e.fin ? 0 : s;
                        gap      = e.fin;
                        doneNext = e.fin && e.last;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int accC;
        int accM;
        int w0;
        int n;
        reset = 1'b1;
        start = 1'b0;
        bus.conv_valid = 1'b0;
        bus.conv_addr  = '0;
        bus.conv_d0    = '0;
        bus.conv_d1    = '0;
        bus.mxpl_valid = 1'b0;
        bus.mxpl_addr  = '0;
        bus.mxpl_d0    = '0;
        bus.mxpl_d1    = '0;
        bus.mxpl_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single conv: first write visible after the accept edge plus the grant edge.
        startLog.delete();
        sendConv(12'h041, 20'd5, 20'd7, acc);
        bus.conv_valid = 1'b0;
        waitDrain("single conv drain");
        chk("single conv txns", 32'(startLog.size()), 1);
        if (startLog.size() == 1) begin
            chk("single conv latency", 32'(startLog[0].cyc - acc), 1);
            chk("single conv stream", 32'(startLog[0].isMxpl), 0);
        end

        // Single max-pool: (011,3FF,9) (101,7FE,9) (100,3FF,3) (101,7FF,3).
        startLog.delete();
        sendMxpl(10'h3FF, 20'd9, 20'd3, 1'b0, acc);
        bus.mxpl_valid = 1'b0;
        waitDrain("single mxpl drain");
        chk("single mxpl txns", 32'(startLog.size()), 1);
        if (startLog.size() == 1) begin
            chk("single mxpl latency", 32'(startLog[0].cyc - acc), 1);
            chk("single mxpl stream", 32'(startLog[0].isMxpl), 1);
        end

        // Both requesters loaded right after reset: conv, mxpl, conv, mxpl.
        doReset();
        startLog.delete();
        accC = 0;
        accM = 0;
        fork
            begin
                sendConv(12'h100, 20'h11, 20'h12, accC);
                sendConv(12'h101, 20'h13, 20'h14, acc);
                bus.conv_valid = 1'b0;
            end
            begin
                sendMxpl(10'h020, 20'h21, 20'h22, 1'b0, accM);
                sendMxpl(10'h021, 20'h23, 20'h24, 1'b0, w0);
                bus.mxpl_valid = 1'b0;
            end
        join
        waitDrain("alternate drain");
        chk("alternate same accept edge", 32'(accM - accC), 0);
        chk("alternate txns", 32'(startLog.size()), 4);
        if (startLog.size() == 4) begin
            int offs[4];
            offs = '{1, 4, 9, 12};
            for (int i = 0; i < 4; i++) begin
                chk("alternate order", 32'(startLog[i].isMxpl), 32'(i % 2));
                chk("alternate start cycle", 32'(startLog[i].cyc - accC), 32'(offs[i]));
            end
        end

        // start, then three max-pool pairs with the last flagged.
        pulseStart();
        chk("busy after start", 32'(busy), 1);
        sendMxpl(10'h005, 20'h51, 20'h52, 1'b0, acc);
        sendMxpl(10'h006, 20'h61, 20'h62, 1'b0, acc);
        sendMxpl(10'h007, 20'h71, 20'h72, 1'b1, acc);
        bus.mxpl_valid = 1'b0;
        bus.mxpl_last  = 1'b0;
        waitDrain("last mxpl drain");
        chk("busy after done", 32'(busy), 0);

        // Back-to-back conv with valid held high.
        startLog.delete();
        w0 = convWrites;
        for (int i = 0; i < 8; i++) begin
            sendConv(ADDRW'(12'h200 + i), DATAW'($urandom), DATAW'($urandom), acc);
        end
        bus.conv_valid = 1'b0;
        waitDrain("b2b conv drain");
        chk("b2b conv writes", 32'(convWrites - w0), 16);
        chk("b2b conv txns", 32'(startLog.size()), 8);
        if (startLog.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                chk("b2b conv spacing", 32'(startLog[i].cyc - startLog[i-1].cyc), 3);
            end
        end

        // Reset while max-pool beat2 is on the port.
        pulseStart();
        sendMxpl(10'h155, 20'hAAAAA, 20'h55555, 1'b1, acc);
        bus.mxpl_valid = 1'b0;
        bus.mxpl_last  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.cwr && bus.csel == SEL_L1K1) && n < 100);
        if (n >= 100) failNow("mxpl beat2 wait");
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid reset cwr", 32'(bus.cwr), 0);
        chk("mid reset busy", 32'(busy), 0);
        repeat (6) @(posedge clk);
        #1;

        // Randomised traffic on both requesters with random start pulses.
        fork
            begin
                int aC;
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                    sendConv(ADDRW'($urandom), DATAW'($urandom), DATAW'($urandom), aC);
                    if ($urandom_range(0, 1) == 0) bus.conv_valid = 1'b0;
                end
                bus.conv_valid = 1'b0;
            end
            begin
                int aM;
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                    sendMxpl(PADDRW'($urandom), DATAW'($urandom), DATAW'($urandom),
                             ($urandom_range(0, 5) == 0), aM);
                    if ($urandom_range(0, 1) == 0) bus.mxpl_valid = 1'b0;
                end
                bus.mxpl_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    repeat ($urandom_range(5, 40)) @(posedge clk);
                    #1;
                    pulseStart();
                end
            end
        join
        waitDrain("random drain");

        chk("conv queue empty", 32'(expConv.size()), 0);
        chk("mxpl queue empty", 32'(expMxpl.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer_wr_sched.md
Name: layer_wr_sched

Overview:
- Write-port scheduler between the CNN datapath (two-kernel convolution unit, two max-pool units) and the single testbench result-memory write port (cwr/csel/caddr_wr/cdata_wr).
- Accepts paired-kernel conv transactions and paired max-pool transactions and expands each into a sequence of single-cycle memory writes:
  - conv pair: 2 beats.
  - max-pool pair: 4 beats, which also performs flattening.
- Arbitrates fairly between the two requesters.
- Owns the busy/done handshake for the whole layer pipeline.

Parameters:
- DATAW, 20, data width of every memory word.
- ADDRW, 12, memory address width (64x64 grid).
- PADDRW, 10, pooled-map address width (32x32 grid).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- start  in  1  one-cycle pulse; sets busy.
- conv_valid  in  1  conv transaction offered.
- conv_ready  out  1  conv holding register empty; equals !conv_full.
- conv_addr  in  ADDRW  pixel address of conv result.
- conv_d0  in  DATAW  kernel-0 conv result.
- conv_d1  in  DATAW  kernel-1 conv result.
- mxpl_valid  in  1  max-pool transaction offered.
- mxpl_ready  out  1  max-pool holding register empty; equals !mxpl_full.
- mxpl_addr  in  PADDRW  pooled pixel address.
- mxpl_d0  in  DATAW  kernel-0 pooled value.
- mxpl_d1  in  DATAW  kernel-1 pooled value.
- mxpl_last  in  1  marks the final max-pool transaction of the image.
- busy  out  1  layer pipeline active.
- done  out  1  one-cycle pulse after the final write.
- cwr  out  1  memory write strobe.
- csel  out  3  memory select.
- caddr_wr  out  ADDRW  write address.
- cdata_wr  out  DATAW  write data.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - Next posedge clears both holding registers, state=IDLE, beat=0, last_grant=MXPL.
  - busy=0, done=0, cwr=0, csel=000, caddr_wr=0, cdata_wr=0.
  - Applies mid-transaction: in-flight beats are discarded and cwr is 0 from the next cycle.
- Accept:
  - On the edge where valid && ready, the payload is captured into that requester's holding register and full is set.
  - ready = !full (registered, no bypass).
  - The holding register is cleared on the edge that issues its transaction's last beat.
- States: IDLE, CONV, MXPL. beat is a 2-bit counter.
- Grant (IDLE, or the edge after a last beat):
  - Only one register full: grant that requester.
  - Both full: grant the requester != last_grant, then update last_grant. Reset value MXPL means conv wins the first tie.
  - Start edge: state=CONV or MXPL, beat0 is registered onto the outputs, so cwr is high in the following cycle. Latency from accept edge to first cwr-high cycle = 2 edges.
- Beat sequence (all outputs registered; cwr=1 for every beat, including the flattening writes):
  - CONV beat0: csel=001, caddr_wr=conv_addr, cdata_wr=d0.
  - CONV beat1: csel=010, caddr_wr=conv_addr, cdata_wr=d1.
  - MXPL beat0: csel=011, caddr_wr={00,mxpl_addr}, cdata_wr=d0.
  - MXPL beat1: csel=101, caddr_wr={0,mxpl_addr,0}, cdata_wr=d0.
  - MXPL beat2: csel=100, caddr_wr={00,mxpl_addr}, cdata_wr=d1.
  - MXPL beat3: csel=101, caddr_wr={0,mxpl_addr,1}, cdata_wr=d1.
- After the last beat:
  - If a holding register is full, the next grant occurs at the next edge, giving exactly one idle cycle (cwr=0, csel=000) between transactions.
  - Otherwise state goes to IDLE.
  - cwr=0 and csel=000 whenever no beat is registered.
- busy/done:
  - start sets busy on its edge.
  - On the edge after the last beat of a transaction captured with mxpl_last=1: busy clears and done pulses high for exactly one cycle.
  - start while busy is ignored.
  - Requests are accepted regardless of busy.
- Simultaneous events:
  - Accept and drain on the same requester in the same edge cannot happen, because ready is low while full.
  - Accept on one requester while the other drains is legal.

Decomposition:
- Shared package:
  - csel encodings: SEL_NONE=000, SEL_L0K0=001, SEL_L0K1=010, SEL_L1K0=011, SEL_L1K1=100, SEL_L2=101.
  - State encodings.
  - DATAW/ADDRW defaults.
- Sub-module: sched_hold_reg, a payload register plus full flag and valid/ready handshake. Instantiated twice, once for conv and once for max-pool.
- Arbitration, beat FSM and output registers stay in the top.

Test Plan:
- Reset mid-MXPL beat2 → next cycle cwr=0, csel=000, busy=0; both ready=1.
- Single conv (addr=0x041, d0=5, d1=7) into IDLE → 2 edges later: cwr=1, csel=001, addr 0x041, data 5; next cycle csel=010, data 7; then cwr=0.
- Single mxpl (addr=0x3FF, d0=9, d1=3) → four consecutive writes:
  - (011, 0x3FF, 9)
  - (101, 0x7FE, 9)
  - (100, 0x3FF, 3)
  - (101, 0x7FF, 3)
- Both requesters full from reset → order conv, mxpl, conv, mxpl (alternating), one idle cycle between transactions; ready rises the cycle after each drain.
- start, then 3 mxpl with the third carrying mxpl_last=1 → busy high throughout; done high exactly one cycle after the final (101, addr*2+1) write; busy low in that same cycle.
- Back-to-back conv valid held high for 8 transactions → exactly 16 writes with csel alternating 001/010, no lost or duplicated addresses.
